// File: rtl/cpu_mem_loader_pkg.sv
// Shared types and defaults for the cpu memory loader.
package cpu_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_e;

    localparam int unsigned DEF_IMEM_BASE = 0;
    localparam int unsigned DEF_DMEM_BASE = 0;
    localparam int unsigned DEF_ADDR_STEP = 4;

endpackage

// File: rtl/cpu_mem_loader_mem_addr_gen.sv
// Word counter and base + idx*step address generator,
// shared by the load and dump phases.
module mem_addr_gen #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    output logic [CNT_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr
);

    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Wraps modulo 2**ADDR_W by construction.
    assign addr = base + (ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP));
    assign idx  = idx_q;

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams images into imem/dmem, runs the cpu
// for a set number of cycles, then dumps the dmem window.
module cpu_mem_loader
    import cpu_mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned IMEM_BASE = DEF_IMEM_BASE,
    parameter int unsigned DMEM_BASE = DEF_DMEM_BASE,
    parameter int unsigned ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  imem_words,
    input  logic [CNT_W-1:0]  dmem_words,
    input  logic [31:0]       run_cycles,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  imem_q, imem_d;
    logic [CNT_W-1:0]  dmem_q, dmem_d;
    logic [31:0]       run_q, run_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    logic              idx_clr;
    logic              idx_inc;
    logic [ADDR_W-1:0] gen_base;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] gen_addr;

    // First non-empty phase strictly after `from`.
    function automatic state_e phase_after(
        input state_e           from,
        input logic [CNT_W-1:0] iw,
        input logic [CNT_W-1:0] dw,
        input logic [31:0]      rc
    );
        if (from == IDLE && iw != '0)
            return LOAD_I;
        if ((from == IDLE || from == LOAD_I) && dw != '0)
            return LOAD_D;
        if ((from == IDLE || from == LOAD_I || from == LOAD_D) && rc != '0)
            return RUN;
        if (dw != '0)
            return DUMP_RD;
        return DONE;
    endfunction

    mem_addr_gen #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .base (gen_base),
        .idx  (idx),
        .addr (gen_addr)
    );

    always_comb begin
        state_d     = state_q;
        imem_d      = imem_q;
        dmem_d      = dmem_q;
        run_d       = run_q;
        cyc_d       = cyc_q;
        m_data_d    = m_data_q;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        gen_base    = ADDR_W'(DMEM_BASE);
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        cpu_enable  = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    imem_d  = imem_words;
                    dmem_d  = dmem_words;
                    run_d   = run_cycles;
                    cyc_d   = '0;
                    idx_clr = 1'b1;
                    state_d = phase_after(IDLE, imem_words,
                                          dmem_words, run_cycles);
                end
            end
            LOAD_I: begin
                gen_base  = ADDR_W'(IMEM_BASE);
                s_ready   = 1'b1;
                wen_ext   = s_valid;
                addr_ext  = gen_addr;
                wdata_ext = s_data;
                if (s_valid) begin
                    if (idx == imem_q - 1'b1) begin
                        idx_clr = 1'b1;
                        state_d = phase_after(LOAD_I, imem_q, dmem_q, run_q);
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            LOAD_D: begin
                s_ready     = 1'b1;
                wen_ext_2   = s_valid;
                addr_ext_2  = gen_addr;
                wdata_ext_2 = s_data;
                if (s_valid) begin
                    if (idx == dmem_q - 1'b1) begin
                        idx_clr = 1'b1;
                        state_d = phase_after(LOAD_D, imem_q, dmem_q, run_q);
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            RUN: begin
                cpu_enable = 1'b1;
                if (cyc_q == run_q - 32'd1) begin
                    cyc_d   = '0;
                    state_d = phase_after(RUN, imem_q, dmem_q, run_q);
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = gen_addr;
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                m_data_d = rdata_ext_2;
                state_d  = DUMP_OUT;
            end
            DUMP_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (idx == dmem_q - 1'b1) begin
                        idx_clr = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = DUMP_RD;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            imem_q   <= '0;
            dmem_q   <= '0;
            run_q    <= '0;
            cyc_q    <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            imem_q   <= imem_d;
            dmem_q   <= dmem_d;
            run_q    <= run_d;
            cyc_q    <= cyc_d;
            m_data_q <= m_data_d;
        end
    end

    assign m_data  = m_data_q;
    assign ren_ext = 1'b0;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Self-checking bench for cpu_mem_loader with a behavioural
// data-memory model and a job-level reference.
module tb_cpu_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  imem_words;
    logic [9:0]  dmem_words;
    logic [31:0] run_cycles;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem_mem [logic [31:0]];

    always #5 clk = ~clk;

    cpu_mem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_words  (imem_words),
        .dmem_words  (dmem_words),
        .run_cycles  (run_cycles),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int iw;
        int dw;
        int rc;
        int vmode;
        int rmode;
        bit midstart;
        int exp_busy;
    } vec_t;

    // One complete job; the reference is the list of words streamed in,
    // their word-indexed addresses, and the run length.
    task automatic run_job(input vec_t v, input bit fixed);
        logic [31:0] iq[$];
        logic [31:0] dq[$];
        logic [31:0] src[$];
        logic [31:0] prev_data = '0;
        logic [31:0] ren_addr = '0;
        int ni = 0, nd = 0, nout = 0;
        int en_cnt = 0, en_rise = 0, done_cnt = 0;
        int busy_cnt = 0, wait_cnt = 0, cyc = 0;
        bit prev_en = 0, prev_stall = 0, ren_prev = 0, fin = 0;
        bit vbit;

        if (fixed) begin
            iq = '{32'h20080005, 32'h20090007, 32'h01095020};
            dq = '{32'h0000000A, 32'h0000000B};
        end else begin
            for (int i = 0; i < v.iw; i++) iq.push_back($urandom);
            for (int i = 0; i < v.dw; i++) dq.push_back($urandom);
        end
        src = {iq, dq};

        @(negedge clk);
        start      = 1'b1;
        imem_words = 10'(v.iw);
        dmem_words = 10'(v.dw);
        run_cycles = 32'(v.rc);
        s_valid    = 1'b0;
        m_ready    = 1'b1;

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            start = v.midstart && (cyc == 3);
            if (cyc == 0 || start) begin
                imem_words = 10'($urandom_range(1, 1023));
                dmem_words = 10'($urandom_range(1, 1023));
                run_cycles = $urandom_range(1, 500);
            end
            case (v.vmode)
                0: vbit = 1'b1;
                1: vbit = (cyc % 2 == 0);
                default: vbit = 1'($urandom_range(0, 1));
            endcase
            if (src.size() > 0 && vbit) begin
                s_valid = 1'b1;
                s_data  = src[0];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end
            case (v.rmode)
                0: m_ready = 1'b1;
                1: begin
                    if (m_valid && wait_cnt < 5) begin
                        m_ready = 1'b0;
                        wait_cnt++;
                    end else begin
                        m_ready = 1'b1;
                        if (m_valid) wait_cnt = 0;
                    end
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (ren_prev && dmem_mem.exists(ren_addr))
                rdata_ext_2 = dmem_mem[ren_addr];
            else
                rdata_ext_2 = $urandom;
            #1;
            if (busy) busy_cnt++;
            if (cyc == 0) chk("ren_ext_const", ren_ext, 0);
            if (s_ready)
                chk("wen_follows_valid", wen_ext | wen_ext_2, s_valid);
            if (wen_ext && wen_ext_2) chk("dual_write", 1, 0);
            if (wen_ext) begin
                chk("imem_addr", addr_ext, 32'(4 * ni));
                if (ni < iq.size())
                    chk("imem_data", wdata_ext, iq[ni]);
                else
                    chk("imem_extra", ni, iq.size());
                ni++;
            end
            if (wen_ext_2) begin
                chk("dmem_addr", addr_ext_2, 32'(4 * nd));
                if (nd < dq.size())
                    chk("dmem_data", wdata_ext_2, dq[nd]);
                else
                    chk("dmem_extra", nd, dq.size());
                dmem_mem[addr_ext_2] = wdata_ext_2;
                nd++;
            end
            if (s_valid && s_ready) void'(src.pop_front());
            if (cpu_enable) begin
                chk("run_quiet", {wen_ext, wen_ext_2, ren_ext_2}, 0);
                en_cnt++;
                if (!prev_en) en_rise++;
            end
            prev_en = cpu_enable;
            if (prev_stall) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", m_data, prev_data);
                chk("no_ren_in_stall", ren_ext_2, 0);
            end
            if (ren_ext_2) chk("dump_addr", addr_ext_2, 32'(4 * nout));
            if (m_valid && m_ready) begin
                if (nout < dq.size())
                    chk("dump_data", m_data, dq[nout]);
                else
                    chk("dump_extra", nout, dq.size());
                nout++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            ren_prev   = ren_ext_2;
            ren_addr   = addr_ext_2;
            if (done) begin
                done_cnt++;
                fin = 1;
            end
            cyc++;
        end

        chk("job_timeout", fin, 1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("imem_writes", ni, v.iw);
        chk("dmem_writes", nd, v.dw);
        chk("dump_words", nout, v.dw);
        chk("run_len", en_cnt, v.rc);
        chk("run_contig", en_rise, (v.rc > 0) ? 1 : 0);
        chk("done_count", done_cnt, 1);
        if (v.exp_busy >= 0) chk("busy_cycles", busy_cnt, v.exp_busy);
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        // busy cycles at full rate: I + D + R + 3*D + 1 (DONE)
        tbl[0] = '{3, 2, 4, 0, 0, 0, 16};
        tbl[1] = '{4, 0, 0, 1, 0, 0, -1};
        tbl[2] = '{1, 2, 1, 0, 1, 0, -1};
        tbl[3] = '{0, 0, 2, 0, 0, 0, 3};
        tbl[4] = '{0, 3, 0, 0, 0, 1, 13};
        tbl[5] = '{2, 0, 3, 0, 0, 1, 6};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[7] = '{5, 5, 5, 2, 2, 0, -1};

        rst         = 1'b1;
        start       = 1'b0;
        imem_words  = '0;
        dmem_words  = '0;
        run_cycles  = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        rdata_ext_2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", cpu_enable, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_wen", {wen_ext, wen_ext_2, ren_ext_2}, 0);
        chk("rst_addr", addr_ext | addr_ext_2, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_job(tbl[i], i == 0);

        // Reset in the middle of RUN aborts and drops cpu_enable.
        @(negedge clk);
        start      = 1'b1;
        imem_words = '0;
        dmem_words = '0;
        run_cycles = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_run_en", cpu_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_en", cpu_enable, 0);
        chk("abort_busy", busy, 0);
        run_job(tbl[0], 1'b1);

        for (int k = 0; k < 6; k++) begin
            rv.iw       = $urandom_range(0, 6);
            rv.dw       = $urandom_range(0, 6);
            rv.rc       = $urandom_range(0, 5);
            rv.vmode    = $urandom_range(0, 2);
            rv.rmode    = $urandom_range(0, 2);
            rv.midstart = 1'($urandom_range(0, 1));
            rv.exp_busy = -1;
            run_job(rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
